irq_ctrl: RTL and testbench

//  Prioritised interrupt controller in front of the special-register block's irq_in input.

---
 rtl/irq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Prioritised interrupt controller sitting in front of the special-register
//   block's irq_in. Latches edge requests (level requests are read live),
//   applies a software mask and presents one request at a time to the core.
//   It remembers which source is in service so the handler can read it back.
//   irq_out is sequenced against irq_en/irq_ack so the core never sees a
//   second entry while a handler is still running.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   src_in     request lines, bit 0 = highest priority
//   irq_en     core interrupt-enable mode bit
//   irq_ack    one-cycle pulse: core has vectored to the handler
//   irq_out    request to the core
//   cfg_we     config write strobe
//   cfg_sel    register select: 0 PEND, 1 MASK, 2 EDGE, 3 ACTIVE
//   cfg_wdata  config write data
//   cfg_rdata  config read data, combinational from cfg_sel
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_in,
  input  logic            irq_en,
  input  logic            irq_ack,
  output logic            irq_out,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_t;

  state_t          r_state, w_state_nxt;
  logic [NSRC-1:0] r_pend_lat;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_prev;
  logic [3:0]      r_id, w_id_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_seen_dis, w_seen_nxt;

  logic [NSRC-1:0] w_pend, w_elig, w_rise, w_clr, w_ack_clr, w_lat_nxt, w_id_oh;
  logic [3:0]      w_win;
  logic            w_any, w_id_elig;
  logic            w_wr_pend, w_wr_mask, w_wr_edge;
  logic            w_unused;

  function automatic logic [15:0] pad16(input logic [NSRC-1:0] v);
    return 16'(v);
  endfunction

  assign w_unused  = ^cfg_wdata;

  assign w_wr_pend = cfg_we && (cfg_sel == 2'd0);
  assign w_wr_mask = cfg_we && (cfg_sel == 2'd1);
  assign w_wr_edge = cfg_we && (cfg_sel == 2'd2);

  // Edge sources read their latch, level sources read the pin directly.
  assign w_pend = (r_pend_lat & r_edge) | (src_in & ~r_edge);
  assign w_elig = w_pend & r_mask;
  assign w_rise = src_in & ~r_prev & r_edge;

  // One-hot of the in-service id and its eligibility, without indexing by a
  // 4-bit id into a narrower vector.
  always_comb begin
    w_id_oh   = '0;
    w_id_elig = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_id == 4'(i)) begin
        w_id_oh[i] = 1'b1;
        w_id_elig  = w_elig[i];
      end
    end
  end

  // Lowest set index wins.
  always_comb begin
    w_win = '0;
    w_any = |w_elig;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 4'(i);
    end
  end

  // Ack and W1C both clear; a new rising edge in the same cycle is ORed in
  // afterwards so it always survives. Level sources keep no latched state.
  assign w_ack_clr = (r_state == S_REQ && irq_ack) ? w_id_oh : '0;
  assign w_clr     = (w_wr_pend ? cfg_wdata[NSRC-1:0] : '0) | w_ack_clr;
  assign w_lat_nxt = ((r_pend_lat & ~w_clr) | w_rise) & r_edge;

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_valid_nxt = r_valid;
    w_seen_nxt  = r_seen_dis;
    irq_out     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (irq_en && w_any) begin
          w_state_nxt = S_REQ;
          w_id_nxt    = w_win;
          w_valid_nxt = 1'b1;
        end
      end
      S_REQ: begin
        irq_out = 1'b1;
        if (irq_ack) begin
          w_state_nxt = S_SERV;
          w_seen_nxt  = 1'b0;
        end else if (!irq_en || !w_id_elig) begin
          // Request withdrawn before the core took it.
          w_state_nxt = S_IDLE;
          w_id_nxt    = '0;
          w_valid_nxt = 1'b0;
        end
      end
      S_SERV: begin
        // Handler done once irq_en has gone low and come back high.
        if (irq_en && r_seen_dis) begin
          w_state_nxt = S_IDLE;
          w_id_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_seen_nxt  = 1'b0;
        end else if (!irq_en) begin
          w_seen_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_id_nxt    = '0;
        w_valid_nxt = 1'b0;
        w_seen_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_id       <= '0;
      r_valid    <= 1'b0;
      r_seen_dis <= 1'b0;
      r_pend_lat <= '0;
      r_mask     <= '0;
      r_edge     <= '1;
      r_prev     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_id       <= w_id_nxt;
      r_valid    <= w_valid_nxt;
      r_seen_dis <= w_seen_nxt;
      r_pend_lat <= w_lat_nxt;
      r_prev     <= src_in;
      if (w_wr_mask) r_mask <= cfg_wdata[NSRC-1:0];
      if (w_wr_edge) r_edge <= cfg_wdata[NSRC-1:0];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      2'd0:    cfg_rdata = pad16(w_pend);
      2'd1:    cfg_rdata = pad16(r_mask);
      2'd2:    cfg_rdata = pad16(r_edge);
      default: cfg_rdata = {r_valid, 11'b0, r_id};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int NSRC = 8;
  localparam logic [15:0] ALL = 16'((1 << NSRC) - 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src_in;
  logic            irq_en, irq_ack, irq_out, cfg_we;
  logic [1:0]      cfg_sel;
  logic [15:0]     cfg_wdata, cfg_rdata;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .src_in(src_in), .irq_en(irq_en),
    .irq_ack(irq_ack), .irq_out(irq_out), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending bits, configuration, and the handler phase
  // (0 idle, 1 requesting, 2 in service).
  logic [15:0] m_lat, m_mask, m_edge, m_prev;
  int          m_phase, m_id;
  bit          m_seen;

  task automatic model_reset();
    m_lat = 0; m_mask = 0; m_edge = ALL; m_prev = 0;
    m_phase = 0; m_id = 0; m_seen = 0;
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] s = 16'(src_in);
    logic [15:0] p = 0;
    for (int i = 0; i < NSRC; i++)
      p[i] = m_edge[i] ? m_lat[i] : s[i];
    return p;
  endfunction

  function automatic logic [15:0] model_rdata(logic [1:0] sel);
    case (sel)
      2'd0:    return model_pend();
      2'd1:    return m_mask;
      2'd2:    return m_edge;
      default: return {(m_phase != 0), 11'b0, 4'(m_id)};
    endcase
  endfunction

  task automatic model_tick();
    logic [15:0] s = 16'(src_in);
    logic [15:0] elig = model_pend() & m_mask;
    int win = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = i;
    for (int i = 0; i < NSRC; i++) begin
      if (!m_edge[i]) m_lat[i] = 0;
      else begin
        if (cfg_we && cfg_sel == 0 && cfg_wdata[i]) m_lat[i] = 0;
        if (m_phase == 1 && irq_ack && m_id == i)   m_lat[i] = 0;
        if (s[i] && !m_prev[i])                     m_lat[i] = 1;
      end
    end
    if (m_phase == 0) begin
      if (irq_en && win >= 0) begin m_phase = 1; m_id = win; end
    end else if (m_phase == 1) begin
      if (irq_ack) begin m_phase = 2; m_seen = 0; end
      else if (!irq_en || !elig[m_id]) begin m_phase = 0; m_id = 0; end
    end else begin
      if (irq_en && m_seen) begin m_phase = 0; m_id = 0; m_seen = 0; end
      else if (!irq_en) m_seen = 1;
    end
    if (cfg_we && cfg_sel == 1) m_mask = cfg_wdata & ALL;
    if (cfg_we && cfg_sel == 2) m_edge = cfg_wdata & ALL;
    m_prev = s;
  endtask

  task automatic step();
    @(negedge clk);
    check_eq("irq_out", 16'(irq_out), 16'(m_phase == 1));
    check_eq($sformatf("rdata sel%0d", cfg_sel), cfg_rdata, model_rdata(cfg_sel));
    model_tick();
    @(posedge clk); #1;
    irq_ack = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic wr(logic [1:0] sel, logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    step();
  endtask

  task automatic expect_reg(string tag, logic [1:0] sel, logic [15:0] exp);
    cfg_sel = sel; #1;
    check_eq(tag, cfg_rdata, exp);
  endtask

  task automatic expect_irq(string tag, logic exp);
    check_eq(tag, 16'(irq_out), 16'(exp));
  endtask

  initial begin
    rst = 1'b1; src_in = '0; irq_en = 1'b0; irq_ack = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = '0;
    model_reset();
    #2;
    expect_irq("rst irq", 1'b0);
    expect_reg("rst pend", 2'd0, 16'h0000);
    expect_reg("rst mask", 2'd1, 16'h0000);
    expect_reg("rst edge", 2'd2, ALL);
    expect_reg("rst active", 2'd3, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // single edge source
    wr(2'd1, 16'h000F);
    irq_en = 1'b1; src_in = 8'h04; step(); src_in = '0;
    expect_reg("t1 pend", 2'd0, 16'h0004);
    expect_irq("t1 irq early", 1'b0);
    step();
    expect_irq("t1 irq", 1'b1);
    expect_reg("t1 active", 2'd3, 16'h8002);
    irq_ack = 1'b1; step();
    expect_irq("t2 irq after ack", 1'b0);
    expect_reg("t2 pend", 2'd0, 16'h0000);
    expect_reg("t2 active serv", 2'd3, 16'h8002);
    irq_en = 1'b0; step(); irq_en = 1'b1; step();
    expect_reg("t2 active idle", 2'd3, 16'h0000);

    // two sources, priority and back-to-back
    wr(2'd1, 16'h00FF);
    src_in = 8'h0A; step(); src_in = '0; step();
    expect_reg("t3 active1", 2'd3, 16'h8001);
    irq_ack = 1'b1; step();
    irq_en = 1'b0; step(); irq_en = 1'b1; step();
    expect_irq("t3 gap", 1'b0);
    step();
    expect_irq("t3 irq2", 1'b1);
    expect_reg("t3 active2", 2'd3, 16'h8003);
    irq_ack = 1'b1; step();
    irq_en = 1'b0; step(); irq_en = 1'b1; step();

    // level source held through iret, then released before iret
    wr(2'd2, 16'h00FE);
    src_in = 8'h01; step();
    expect_irq("t4 irq", 1'b1);
    irq_ack = 1'b1; step();
    irq_en = 1'b0; step(); irq_en = 1'b1; step();
    expect_irq("t4 idle", 1'b0);
    step();
    expect_irq("t4 reentry", 1'b1);
    irq_ack = 1'b1; step();
    src_in = '0;
    irq_en = 1'b0; step(); irq_en = 1'b1; step(); step();
    expect_irq("t4 no reentry", 1'b0);
    expect_reg("t4 active", 2'd3, 16'h0000);

    // mask withdrawal while requesting
    wr(2'd2, 16'h00FF);
    src_in = 8'h10; step(); src_in = '0; step();
    expect_irq("t5 irq", 1'b1);
    expect_reg("t5 active", 2'd3, 16'h8004);
    wr(2'd1, 16'h0000); step();
    expect_irq("t5 withdrawn", 1'b0);
    expect_reg("t5 active idle", 2'd3, 16'h0000);
    expect_reg("t5 pend kept", 2'd0, 16'h0010);
    wr(2'd0, 16'h0010);

    // W1C racing a new edge
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_wdata = 16'h0020; src_in = 8'h20; step();
    src_in = '0;
    expect_reg("t6 set wins", 2'd0, 16'h0020);
    wr(2'd0, 16'h0020);
    expect_reg("t6 cleared", 2'd0, 16'h0000);

    // async reset while requesting
    wr(2'd1, 16'h00FF);
    src_in = 8'h40; step(); src_in = '0; step();
    expect_irq("t7 irq", 1'b1);
    #1 rst = 1'b1; #1;
    model_reset();
    expect_irq("t7 rst req irq", 1'b0);
    expect_reg("t7 rst mask", 2'd1, 16'h0000);
    expect_reg("t7 rst active", 2'd3, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // async reset while in service
    wr(2'd1, 16'h00FF);
    src_in = 8'h01; step(); src_in = 8'h02; step(); src_in = '0;
    irq_ack = 1'b1; step();
    expect_reg("t8 active serv", 2'd3, 16'h8000);
    rst = 1'b1; #1;
    model_reset();
    expect_irq("t8 rst irq", 1'b0);
    expect_reg("t8 rst active", 2'd3, 16'h0000);
    expect_reg("t8 rst pend", 2'd0, 16'h0000);
    expect_reg("t8 rst edge", 2'd2, ALL);
    @(posedge clk); #1 rst = 1'b0;

    // randomized traffic against the model
    irq_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      src_in = NSRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) irq_en = ~irq_en;
      irq_ack = (m_phase == 1) ? ($urandom_range(0, 2) == 0)
                               : ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_we = 1'b1;
        cfg_wdata = 16'($urandom);
      end
      cfg_sel = 2'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
